// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: pushbutton-loaded operands added or subtracted one nibble per cycle.
module nibble_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       x,
  input  logic             pb_a,
  input  logic             pb_b,
  input  logic             pb_go,
  input  logic             sub,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int N = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST = KW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [2:0] s1, s2, s3, armed, ev;
  logic [1:0] vld;
  logic [KW-1:0] pa, pbp, k;
  logic [WIDTH-1:0] opa, opb, acc;
  logic [WIDTH+3:0] acc_nx;
  logic [4:0] sum;
  logic c, ov, ld_ok, start;
  // armed only sets once the synchroniser holds a real low sample, so a button held through reset stays silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      armed <= '0;
      vld <= '0;
    end else begin
      s1 <= {pb_go, pb_b, pb_a};
      s2 <= s1;
      s3 <= s2;
      vld <= {vld[0], 1'b1};
      armed <= armed | (~s2 & {3{vld[1]}});
    end
  end
  assign ev = s2 & ~s3 & armed;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE) ? (ev[2] ? RUN : IDLE) :
               (state == RUN)  ? ((k == LAST) ? FIN : RUN) : IDLE;
  end
  always_comb begin
    busy = (state != IDLE);
    ld_ok = (state == IDLE);
    start = ld_ok & ev[2];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      pa <= '0;
      pbp <= '0;
    end else begin
      if (ld_ok && ev[0]) begin
        a[4*pa +: 4] <= x;
        pa <= (pa == LAST) ? '0 : pa + 1'b1;
      end
      if (ld_ok && ev[1]) begin
        b[4*pbp +: 4] <= x;
        pbp <= (pbp == LAST) ? '0 : pbp + 1'b1;
      end
    end
  end
  // operand snapshots shift right so nibble 0 is always the one being added
  assign sum = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'b0, c};
  assign acc_nx = {sum[3:0], acc};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      acc <= '0;
      c <= 1'b0;
      ov <= 1'b0;
      k <= '0;
      z <= '0;
      carry <= 1'b0;
      ovf <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (start) begin
        opa <= a;
        opb <= sub ? ~b : b;
        c <= sub;
        k <= '0;
      end else if (state == RUN) begin
        opa <= opa >> 4;
        opb <= opb >> 4;
        acc <= acc_nx[WIDTH+3:4];
        c <= sum[4];
        ov <= sum[4] ^ sum[3] ^ opa[3] ^ opb[3];
        k <= k + 1'b1;
      end
      if (state == FIN) begin
        z <= acc;
        carry <= c;
        ovf <= ov;
      end
    end
  end
endmodule
